// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// The one-hot-to-index helper covers requester counts up to ARB_MAX_N.
package arb_pkg;

    localparam int unsigned ARB_MAX_N = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero, so N=2 still gets a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        for (int unsigned w = 1; w < 32; w++) begin
            if ((32'd1 << w) >= n) return w;
        end
        return 32;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: lowest set request at or above ptr, wrapping.
// Uses a doubled request vector so the wrap falls out of one subtraction.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] ptr_oh;
    logic [2*N-1:0] dbl_gnt;

    // Subtracting the pointer bit borrows up to the first request at/above ptr;
    // masking with the inverted difference isolates exactly that bit.
    always_comb begin
        dbl_req = {req, req};
        ptr_oh  = (2*N)'(1) << ptr;
        dbl_gnt = dbl_req & ~(dbl_req - ptr_oh);
        gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/arbiter_rr_lock.sv
// N-way round-robin arbiter with registered one-hot grant, bounded lock mode
// and run-time selectable fixed priority.
module arbiter_rr_lock
    import arb_pkg::*;
#(
    parameter  int unsigned N        = 8,
    parameter  int unsigned MAX_HOLD = 16,
    localparam int unsigned IDX_W    = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             lock_en,
    input  logic             prio_mode,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int unsigned HC_W = $clog2(MAX_HOLD) + 1;

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [N-1:0]           rr_oh;
    logic [N-1:0]           fp_oh;
    logic [N-1:0]           win_oh;
    logic [ARB_MAX_N-1:0]   win_ext;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       win_next;
    logic                   keep;
    logic                   arbitrate;

    arb_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (rr_oh)
    );

    // Fixed priority is the same search anchored at index 0.
    arb_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick_fp (
        .req (req),
        .ptr ('0),
        .gnt (fp_oh)
    );

    always_comb begin
        win_oh           = prio_mode ? fp_oh : rr_oh;
        win_ext          = '0;
        win_ext[N-1:0]   = win_oh;
        win_idx          = IDX_W'(onehot_to_idx(win_ext));
        win_next         = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        keep        = 1'b0;
        arbitrate   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) arbitrate = 1'b1;
            end
            ST_GRANT: begin
                keep = lock_en && req[gnt_idx_q] && (32'(hold_cnt_q) < MAX_HOLD - 1);
                if (keep) begin
                    if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (|req) begin
                    arbitrate = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    hold_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arbitrate) begin
            state_d     = ST_GRANT;
            gnt_d       = win_oh;
            gnt_valid_d = 1'b1;
            gnt_idx_d   = win_idx;
            hold_cnt_d  = '0;
            ptr_d       = win_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Bench for arbiter_rr_lock: directed vector table, hand sequences for reset
// and odd N, then random traffic against a queue-free behavioural model.
module tb_arbiter_rr_lock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] req8 = '0;
    logic       lock8 = 1'b0;
    logic       prio8 = 1'b0;
    logic [7:0] gnt8;
    logic       gv8;
    logic [2:0] idx8;

    logic [4:0] req5 = '0;
    logic       lock5 = 1'b0;
    logic       prio5 = 1'b0;
    logic [4:0] gnt5;
    logic       gv5;
    logic [2:0] idx5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arbiter_rr_lock #(.N(8), .MAX_HOLD(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .lock_en(lock8), .prio_mode(prio8),
        .gnt(gnt8), .gnt_valid(gv8), .gnt_idx(idx8)
    );

    arbiter_rr_lock #(.N(5), .MAX_HOLD(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .lock_en(lock5), .prio_mode(prio5),
        .gnt(gnt5), .gnt_valid(gv5), .gnt_idx(idx5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holder, cycles held so far, rotating start index.
    int mdl_n  [2] = '{8, 5};
    int mdl_mh [2] = '{4, 3};
    int m_busy [2];
    int m_hold [2];
    int m_held [2];
    int m_ptr  [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 0; m_hold[u] = 0; m_held[u] = 0; m_ptr[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [7:0] r, input logic lk, input logic pr);
        int start;
        int w;
        if (m_busy[u] != 0 && lk && r[m_hold[u]] && m_held[u] < mdl_mh[u]) begin
            m_held[u]++;
        end else if (r != 8'h00) begin
            start = pr ? 0 : m_ptr[u];
            w = -1;
            for (int k = 0; k < mdl_n[u]; k++) begin
                int j;
                j = (start + k) % mdl_n[u];
                if (w < 0 && r[j]) w = j;
            end
            m_busy[u] = 1;
            m_hold[u] = w;
            m_held[u] = 1;
            m_ptr[u]  = (w + 1) % mdl_n[u];
        end else begin
            m_busy[u] = 0;
        end
    endtask

    function automatic logic [31:0] model_gnt(input int u);
        return (m_busy[u] != 0) ? (32'd1 << m_hold[u]) : 32'd0;
    endfunction

    function automatic logic [31:0] model_idx(input int u);
        return (m_busy[u] != 0) ? 32'(m_hold[u]) : 32'd0;
    endfunction

    // Leaves the bench at posedge+1 after one idle (req=0) edge out of reset.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req8 = '0; req5 = '0;
        #1;
        check("rst_async_gnt8", 32'(gnt8), 32'd0);
        check("rst_async_gv8", 32'(gv8), 32'd0);
        check("rst_async_idx8", 32'(idx8), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_gnt8", 32'(gnt8), 32'd0);
        check("rst_hold_gnt5", 32'(gnt5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_idle_gnt8", 32'(gnt8), 32'd0);
        model_reset();
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       lk;
        logic       pr;
        logic [7:0] g;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic [7:0] r, input logic lk,
                                input logic pr, input logic [7:0] g, input logic [2:0] idx);
        vec_t v;
        v.rst = rst; v.req = r; v.lk = lk; v.pr = pr; v.g = g; v.idx = idx;
        tbl.push_back(v);
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Rotation over all eight requesters, wrapping back to 0.
        for (int i = 0; i < 9; i++) begin
            logic [7:0] g;
            g = 8'd1 << (i % 8);
            add(i == 0, 8'hFF, 1'b0, 1'b0, g, 3'(i % 8));
        end
        // Lock with MAX_HOLD=4: four cycles each, then back to 0.
        for (int i = 0; i < 9; i++) begin
            add(i == 0, 8'h05, 1'b1, 1'b0, (i < 4 || i == 8) ? 8'h01 : 8'h04,
                (i < 4 || i == 8) ? 3'd0 : 3'd2);
        end
        // Holder drops, grant to 7, pointer wraps to 0.
        add(1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 3'd1);
        add(1'b0, 8'h02, 1'b1, 1'b0, 8'h02, 3'd1);
        add(1'b0, 8'h02, 1'b1, 1'b0, 8'h02, 3'd1);
        add(1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 3'd7);
        add(1'b0, 8'h81, 1'b0, 1'b0, 8'h01, 3'd0);
        // Fixed priority, then back to round robin from ptr=3.
        add(1'b1, 8'h0C, 1'b0, 1'b1, 8'h04, 3'd2);
        add(1'b0, 8'h0C, 1'b0, 1'b1, 8'h04, 3'd2);
        add(1'b0, 8'h0C, 1'b0, 1'b1, 8'h04, 3'd2);
        add(1'b0, 8'h0C, 1'b0, 1'b0, 8'h08, 3'd3);
        add(1'b0, 8'h0C, 1'b0, 1'b0, 8'h04, 3'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req8  = tbl[i].req;
            lock8 = tbl[i].lk;
            prio8 = tbl[i].pr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_gnt", i), 32'(gnt8), 32'(tbl[i].g));
            check($sformatf("vec%0d_idx", i), 32'(idx8), 32'(tbl[i].idx));
            check($sformatf("vec%0d_valid", i), 32'(gv8), 32'(|tbl[i].g));
        end

        // Asynchronous reset in the middle of a lock.
        do_reset();
        req8 = 8'h04; lock8 = 1'b1; prio8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lock_pre_rst_gnt", 32'(gnt8), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("midlock_rst_gnt", 32'(gnt8), 32'd0);
        check("midlock_rst_gv", 32'(gv8), 32'd0);
        check("midlock_rst_idx", 32'(idx8), 32'd0);
        req8 = 8'h0C;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_rst_gnt", 32'(gnt8), 32'h04);
        check("post_rst_idx", 32'(idx8), 32'd2);

        // Non-power-of-two N: requesters 0 and 4 alternate.
        do_reset();
        req8 = '0;
        req5 = 5'h11; lock5 = 1'b0; prio5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("n5_alt_gnt", 32'(gnt5), (i % 2 == 0) ? 32'h01 : 32'h10);
            check("n5_alt_idx", 32'(idx5), (i % 2 == 0) ? 32'd0 : 32'd4);
        end

        // Random traffic on both instances against the model.
        do_reset();
        req8 = '0; lock8 = 1'b0; prio8 = 1'b0;
        req5 = '0; lock5 = 1'b0; prio5 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) req8 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) req8 = '0;
            if ($urandom_range(0, 7) == 0) lock8 = 1'($urandom);
            if ($urandom_range(0, 15) == 0) prio8 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) req5 = 5'($urandom);
            if ($urandom_range(0, 15) == 0) req5 = '0;
            if ($urandom_range(0, 7) == 0) lock5 = 1'($urandom);
            if ($urandom_range(0, 15) == 0) prio5 = 1'($urandom);
            @(posedge clk); #1;
            model_step(0, req8, lock8, prio8);
            model_step(1, {3'b000, req5}, lock5, prio5);
            check("rnd8_gnt", 32'(gnt8), model_gnt(0));
            check("rnd8_idx", 32'(idx8), model_idx(0));
            check("rnd8_valid", 32'(gv8), 32'(m_busy[0] != 0));
            check("rnd5_gnt", 32'(gnt5), model_gnt(1));
            check("rnd5_idx", 32'(idx5), model_idx(1));
            check("rnd5_valid", 32'(gv5), 32'(m_busy[1] != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
